voice_sched: RTL and testbench

VOICE_SCHED -- requirements
Module: voice_sched

---
 rtl/voice_sched_pkg.sv | 18 +
 rtl/voice_regs.sv | 65 ++++++
 rtl/voice_sched.sv | 121 ++++++++++++
 tb/tb_voice_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_sched_pkg.sv
// rtl/voice_sched_pkg.sv - shared widths and sweep FSM states for the voice scheduler
package voice_sched_pkg;

  localparam int NUM_VOICES = 4;
  localparam int VIDX_W     = 2;
  localparam int PHASE_W    = 16;
  localparam int SAMPLE_W   = 8;
  localparam int ACC_W      = 10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ADV,
    DONE
  } state_t;

endpackage

// File: rtl/voice_regs.sv
// rtl/voice_regs.sv - live inc/en config, per-frame shadow copies and voice phase accumulators
module voice_regs
  import voice_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we_i,
  input  logic [VIDX_W-1:0]   cfg_voice_i,
  input  logic [PHASE_W-1:0]  cfg_inc_i,
  input  logic                cfg_en_i,
  input  logic                snap_i,
  input  logic                adv_i,
  input  logic [VIDX_W-1:0]   voice_i,
  output logic                cur_en_o,
  output logic [SAMPLE_W-1:0] cur_addr_o,
  output logic [SAMPLE_W-1:0] phase0_o
);

  logic [NUM_VOICES-1:0][PHASE_W-1:0] inc_q, inc_d;
  logic [NUM_VOICES-1:0][PHASE_W-1:0] inc_sh_q, inc_sh_d;
  logic [NUM_VOICES-1:0][PHASE_W-1:0] phase_q, phase_d;
  logic [NUM_VOICES-1:0]              en_q, en_d;
  logic [NUM_VOICES-1:0]              en_sh_q, en_sh_d;

  always_comb begin
    inc_d    = inc_q;
    en_d     = en_q;
    inc_sh_d = inc_sh_q;
    en_sh_d  = en_sh_q;
    phase_d  = phase_q;
    if (cfg_we_i) begin
      inc_d[cfg_voice_i] = cfg_inc_i;
      en_d[cfg_voice_i]  = cfg_en_i;
    end
    // Snapshot takes the registered values, so a write in the same cycle lands after the copy.
    if (snap_i) begin
      inc_sh_d = inc_q;
      en_sh_d  = en_q;
    end
    if (adv_i && en_sh_q[voice_i]) begin
      phase_d[voice_i] = phase_q[voice_i] + inc_sh_q[voice_i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q    <= '0;
      en_q     <= '0;
      inc_sh_q <= '0;
      en_sh_q  <= '0;
      phase_q  <= '0;
    end else begin
      inc_q    <= inc_d;
      en_q     <= en_d;
      inc_sh_q <= inc_sh_d;
      en_sh_q  <= en_sh_d;
      phase_q  <= phase_d;
    end
  end

  assign cur_en_o   = en_sh_q[voice_i];
  assign cur_addr_o = phase_q[voice_i][PHASE_W-1:PHASE_W-SAMPLE_W];
  assign phase0_o   = phase_q[0][PHASE_W-1:PHASE_W-SAMPLE_W];

endmodule

// File: rtl/voice_sched.sv
// rtl/voice_sched.sv - frame-driven sweep over voices sharing one wave ROM, mixing into one sample
module voice_sched
  import voice_sched_pkg::*;
#(
  parameter int NUM_VOICES = voice_sched_pkg::NUM_VOICES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                cfg_we,
  input  logic [VIDX_W-1:0]   cfg_voice,
  input  logic [PHASE_W-1:0]  cfg_inc,
  input  logic                cfg_en,
  output logic                rom_req,
  output logic [SAMPLE_W-1:0] rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun,
  output logic [SAMPLE_W-1:0] phase
);

  state_t              state_q, state_d;
  logic [VIDX_W-1:0]   voice_q, voice_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  logic                overrun_q, overrun_d;
  logic                snap, adv, cur_en;
  logic [SAMPLE_W-1:0] cur_addr;

  voice_regs u_regs (
    .clk         (clk),
    .rst         (rst),
    .cfg_we_i    (cfg_we),
    .cfg_voice_i (cfg_voice),
    .cfg_inc_i   (cfg_inc),
    .cfg_en_i    (cfg_en),
    .snap_i      (snap),
    .adv_i       (adv),
    .voice_i     (voice_q),
    .cur_en_o    (cur_en),
    .cur_addr_o  (cur_addr),
    .phase0_o    (phase)
  );

  always_comb begin
    state_d        = state_q;
    voice_d        = voice_q;
    acc_d          = acc_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    snap           = 1'b0;
    adv            = 1'b0;
    rom_req        = 1'b0;
    rom_addr       = '0;
    overrun_d      = frame_tick && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = ISSUE;
          voice_d = '0;
          acc_d   = '0;
          snap    = 1'b1;
        end
      end
      ISSUE: begin
        rom_req  = cur_en;
        rom_addr = cur_en ? cur_addr : '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cur_en) begin
          acc_d = acc_q + {{(ACC_W-SAMPLE_W){rom_data[SAMPLE_W-1]}}, rom_data};
        end
        state_d = ADV;
      end
      ADV: begin
        adv = 1'b1;
        if (voice_q == VIDX_W'(NUM_VOICES - 1)) begin
          state_d = DONE;
        end else begin
          voice_d = voice_q + VIDX_W'(1);
          state_d = ISSUE;
        end
      end
      DONE: begin
        // Four 8-bit samples fit in 10 bits; dropping two LSBs rescales back to 8.
        sample_d       = acc_q[ACC_W-1 -: SAMPLE_W];
        sample_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      voice_q        <= '0;
      acc_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      voice_q        <= voice_d;
      acc_q          <= acc_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_voice_sched.sv
// tb/tb_voice_sched.sv - directed and randomized frame checks against a frame-level mixing model
module tb_voice_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        cfg_we;
  logic [1:0]  cfg_voice;
  logic [15:0] cfg_inc;
  logic        cfg_en;
  logic        rom_req;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic [7:0]  phase;

  int n_vec = 0;
  int n_bad = 0;

  int         rom_mode;
  logic [7:0] rom_const;
  logic [7:0] rom_tbl [256];

  logic [15:0] m_inc   [4];
  logic [15:0] m_phase [4];
  logic        m_en    [4];
  logic [7:0]  addr_log[$];

  always #5 clk = ~clk;

  voice_sched dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .cfg_we       (cfg_we),
    .cfg_voice    (cfg_voice),
    .cfg_inc      (cfg_inc),
    .cfg_en       (cfg_en),
    .rom_req      (rom_req),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun),
    .phase        (phase)
  );

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    if (rom_mode == 0)      return a;
    else if (rom_mode == 1) return rom_const;
    else                    return rom_tbl[a];
  endfunction

  // Synchronous ROM: data is valid only in the cycle after the request; junk otherwise.
  always @(posedge clk) rom_data <= rom_req ? rom_fn(rom_addr) : 8'hA5;

  always @(negedge clk) if (rom_req) addr_log.push_back(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 4; v++) begin
      m_inc[v] = 16'h0; m_phase[v] = 16'h0; m_en[v] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0; cfg_we = 1'b0; cfg_voice = 2'd0; cfg_inc = 16'h0; cfg_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input logic [1:0] v, input logic [15:0] inc, input logic en);
    cfg_we = 1'b1; cfg_voice = v; cfg_inc = inc; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
    m_inc[v] = inc; m_en[v] = en;
  endtask

  // Entered and left on a negedge; ticks issued back to back land exactly 20 cycles apart.
  // wr_at: -1 none, 0 with the tick, n>0 sampled n cycles after the tick. dup_at>0: extra tick.
  task automatic run_frame(input int wr_at, input logic [1:0] wv, input logic [15:0] winc,
                           input logic wen, input int dup_at);
    int                sum;
    logic signed [7:0] d;
    logic [7:0]        exp_s;
    logic [7:0]        exp_addr[$];
    int                lat;
    int                nvalid;
    sum = 0;
    exp_addr = {};
    for (int v = 0; v < 4; v++) begin
      if (m_en[v]) begin
        exp_addr.push_back(m_phase[v][15:8]);
        d = rom_fn(m_phase[v][15:8]);
        sum += d;
        m_phase[v] = m_phase[v] + m_inc[v];
      end
    end
    exp_s = 8'(sum >>> 2);
    addr_log = {};
    frame_tick = 1'b1;
    if (wr_at == 0) begin
      cfg_we = 1'b1; cfg_voice = wv; cfg_inc = winc; cfg_en = wen;
    end
    @(negedge clk);
    frame_tick = 1'b0;
    cfg_we = 1'b0;
    lat = -1;
    nvalid = 0;
    for (int k = 0; k < 19; k++) begin
      if (k == 0) check("busy_in_sweep", busy, 1);
      if (wr_at > 0 && k == wr_at) cfg_we = 1'b0;
      if (wr_at > 0 && k == wr_at - 1) begin
        cfg_we = 1'b1; cfg_voice = wv; cfg_inc = winc; cfg_en = wen;
      end
      if (dup_at > 0 && k == dup_at) begin
        frame_tick = 1'b0;
        check("overrun_pulse", overrun, 1);
      end
      if (dup_at > 0 && k == dup_at + 1) check("overrun_clear", overrun, 0);
      if (dup_at > 0 && k == dup_at - 1) frame_tick = 1'b1;
      if (sample_valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = k;
          check("sample", sample, exp_s);
        end
      end
      @(negedge clk);
    end
    check("valid_latency", lat, 13);
    check("valid_count", nvalid, 1);
    check("busy_after", busy, 0);
    check("sample_held", sample, exp_s);
    check("rom_req_count", addr_log.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++)
      check("rom_addr", addr_log[i], exp_addr[i]);
    check("phase_dbg", phase, m_phase[0][15:8]);
    if (wr_at >= 0) begin
      m_inc[wv] = winc; m_en[wv] = wen;
    end
  endtask

  initial begin
    int nvalid;
    int wr_at;
    rom_mode = 0;
    rom_const = 8'h00;
    for (int i = 0; i < 256; i++) rom_tbl[i] = 8'($urandom);

    do_reset();
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rom_req", rom_req, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_phase", phase, 0);

    // ROM echoes its address; voice 0 steps one ROM entry per frame.
    cfg_write(2'd0, 16'h0100, 1'b1);
    for (int f = 0; f < 5; f++) run_frame(-1, 2'd0, 16'h0, 1'b0, 0);
    check("five_frames_sample", sample, 8'h01);

    // Full-scale positive and negative mixes.
    for (int v = 0; v < 4; v++) cfg_write(2'(v), 16'($urandom), 1'b1);
    rom_mode = 1;
    rom_const = 8'h7F;
    run_frame(-1, 2'd0, 16'h0, 1'b0, 0);
    check("max_pos", sample, 8'h7F);
    rom_const = 8'h80;
    run_frame(-1, 2'd0, 16'h0, 1'b0, 0);
    check("max_neg", sample, 8'h80);

    // Tick during a sweep, then a tick 20 cycles after the first.
    rom_mode = 2;
    run_frame(-1, 2'd0, 16'h0, 1'b0, 5);
    run_frame(-1, 2'd0, 16'h0, 1'b0, 0);

    // Live writes only reach the next sweep.
    cfg_write(2'd2, 16'h0000, 1'b1);
    run_frame(3, 2'd2, 16'h0400, 1'b1, 0);
    run_frame(-1, 2'd0, 16'h0, 1'b0, 0);
    run_frame(0, 2'd2, 16'h0800, 1'b1, 0);
    run_frame(-1, 2'd0, 16'h0, 1'b0, 0);

    // Phase wrap, then reset in the middle of a sweep.
    do_reset();
    cfg_write(2'd0, 16'hFF80, 1'b1);
    run_frame(-1, 2'd0, 16'h0, 1'b0, 0);
    check("phase_pre_wrap", phase, 8'hFF);
    cfg_write(2'd0, 16'h0100, 1'b1);
    run_frame(-1, 2'd0, 16'h0, 1'b0, 0);
    check("phase_wrapped", phase, 8'h00);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    nvalid = 0;
    repeat (5) begin
      if (sample_valid) nvalid++;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("rst_mid_busy_now", busy, 0);
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_phase", phase, 0);
    rst = 1'b0;
    model_reset();
    repeat (15) begin
      if (sample_valid) nvalid++;
      @(negedge clk);
    end
    check("rst_mid_no_valid", nvalid, 0);
    check("rst_mid_sample", sample, 0);
    run_frame(-1, 2'd0, 16'h0, 1'b0, 0);

    // Random configs, random ROM contents and random write timing.
    for (int i = 0; i < 12; i++) begin
      int nw;
      nw = int'($urandom_range(0, 2));
      for (int j = 0; j < nw; j++) cfg_write(2'($urandom), 16'($urandom), 1'($urandom));
      wr_at = int'($urandom_range(0, 13)) - 1;
      run_frame(wr_at, 2'($urandom), 16'($urandom), 1'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
